leglite_fetch: RTL and testbench
================================

Name: leglite_fetch

Overview:
Instruction fetch unit for LEGLite. Holds the PC and fetches 16-bit instructions from instruction memory over a req/ack handshake. Presents the opcode field to the control decoder, then consumes the decoder's branch/uncondbranch outputs and the ALU zero flag to compute the next PC. It is the producer side of the opcode-to-control interface.

Parameters:
PC_WIDTH, 16, PC and imem address width (byte address, instructions 2-byte aligned)
OFF_WIDTH, 9, signed branch word-offset width
RESET_PC, 16'h0000, PC value on reset
ACK_TIMEOUT, 15, cycles waited in FETCH without imem_ack before error (range 1..255)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
run  input  1  leave IDLE and start fetching
halt  input  1  stop after current EXEC
imem_req  output  1  fetch request, held until ack
imem_addr  output  PC_WIDTH  fetch address (= pc)
imem_ack  input  1  read data valid this cycle
imem_rdata  input  16  instruction word
instr  output  16  latched instruction
opcode  output  4  instr[15:12], to control decoder
instr_valid  output  1  one-cycle strobe: instr/opcode valid, branch inputs sampled
branch  input  1  conditional branch, from control
uncondbranch  input  1  unconditional branch, from control
alu_zero  input  1  ALU zero flag
branch_offset  input  OFF_WIDTH  signed word offset
pc  output  PC_WIDTH  current PC
halted  output  1  in HALT state
fetch_error  output  1  sticky: imem ack timeout
taken_count  output  16  taken-branch count (optional feature)

Behaviour:
- Reset (reset_n low, async): state=IDLE; pc=RESET_PC; instr=0; imem_req=0; instr_valid=0; halted=0; fetch_error=0; timeout counter=0; taken_count=0. Reset mid-transaction drops imem_req immediately.
- States: IDLE, FETCH, EXEC, HALT. All outputs registered except opcode (=instr[15:12]) and imem_addr (=pc).
- IDLE: imem_req=0. run=1 -> FETCH; halt=1 (priority over run) -> HALT.
- FETCH: imem_req=1, imem_addr stable. On imem_ack: instr<=imem_rdata, counter cleared, -> EXEC. Without ack the counter increments; when it reaches ACK_TIMEOUT: fetch_error<=1, imem_req<=0, -> HALT. halt is ignored in FETCH; the request always completes or times out.
- EXEC: exactly one cycle; instr_valid=1. taken = uncondbranch | (branch & alu_zero). Next pc = pc + (sign_extend(branch_offset) << 1) if taken, else pc + 2. Arithmetic is mod 2^PC_WIDTH (wraps 16'hFFFE+2 -> 0). Then halt=1 -> HALT, else -> FETCH.
- HALT: sticky until reset; imem_req=0; halted=1; pc and instr frozen; run ignored.
- imem_ack outside FETCH is ignored. branch/uncondbranch/alu_zero/branch_offset are only sampled in EXEC.
- Latency: ack in cycle N -> instr_valid in N+1 -> imem_req with new pc in N+2. Zero-wait-state memory gives 1 instruction per 2 cycles.
- imem_rdata is captured only on ack; instr holds its value between fetches.

Optional Feature:
LEGLITE_FETCH_BRCNT_EN. Defined: taken_count increments in each EXEC cycle with taken=1 and saturates at 16'hFFFF. Undefined: taken_count is tied to 0 and no counter logic is built. The port exists in both builds.

Test Plan:
- Reset, run=1, memory acks on the 1st cycle, rdata=16'h0123 -> imem_addr=0000; instr_valid in the cycle after ack with opcode=0; next imem_addr=0002.
- EXEC with branch=1, alu_zero=1, offset=9'h1FC (-4), pc=0010 -> next pc=0008; same with alu_zero=0 -> next pc=0012.
- uncondbranch=1, offset=+3, pc=FFFE -> pc=0004 (wrap); non-branch at pc=FFFE -> pc=0000.
- No ack for 15 cycles in FETCH -> fetch_error=1, halted=1, imem_req=0 the next cycle; a later ack has no effect.
- halt asserted during FETCH and held -> fetch completes, one EXEC strobe, then HALT with pc advanced; run is ignored thereafter.
- reset_n pulsed low mid-FETCH -> imem_req drops asynchronously, pc=RESET_PC. With LEGLITE_FETCH_BRCNT_EN defined, 3 taken plus 2 not-taken branches -> taken_count=3.

Source files
------------

// File: rtl/leglite_fetch.sv
// ---------------------------------------------------------------------------
// leglite_fetch: LEGLite instruction fetch unit.
//
// Holds the PC and fetches one 16-bit instruction at a time from instruction
// memory over a req/ack handshake. Each fetched instruction is presented to
// the control decoder for one EXEC cycle. In that cycle the decoder's
// branch/uncondbranch outputs and the ALU zero flag select the next PC.
//
// States: IDLE -> FETCH -> EXEC -> FETCH ... ; HALT is sticky until reset.
// A FETCH that sees no ack for ACK_TIMEOUT cycles sets a sticky fetch_error
// and halts.
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   run, halt           start fetching from IDLE / stop after current EXEC
//   imem_req/addr       fetch request (held until ack) and byte address (= pc)
//   imem_ack/rdata      read-data-valid strobe and instruction word
//   instr, opcode       latched instruction and its [15:12] field
//   instr_valid         one-cycle strobe marking the EXEC cycle
//   branch, uncondbranch, alu_zero, branch_offset
//                       next-PC controls, sampled only in EXEC
//   pc, halted          current PC, in HALT state
//   fetch_error         sticky imem ack timeout
//   taken_count         saturating taken-branch count
//
// Optional feature: define LEGLITE_FETCH_BRCNT_EN to build the taken-branch
// counter. Without it taken_count is tied to zero.
// ---------------------------------------------------------------------------
module leglite_fetch #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  OFF_WIDTH   = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 16'h0000,
  parameter int                  ACK_TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 halt,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [15:0]          imem_rdata,
  output logic [15:0]          instr,
  output logic [3:0]           opcode,
  output logic                 instr_valid,
  input  logic                 branch,
  input  logic                 uncondbranch,
  input  logic                 alu_zero,
  input  logic [OFF_WIDTH-1:0] branch_offset,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 halted,
  output logic                 fetch_error,
  output logic [15:0]          taken_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [PC_WIDTH-1:0] pc_nx;
  logic [15:0]         instr_nx;
  logic [7:0]          tcnt, tcnt_nx, tcnt_inc;
  logic                err_nx;
  logic                taken;
  logic [PC_WIDTH-1:0] off_bytes;

  assign imem_addr = pc;
  assign opcode    = instr[15:12];

  assign taken = uncondbranch | (branch & alu_zero);

  // Word offset sign-extended to PC width and scaled to a byte offset.
  assign off_bytes = {{(PC_WIDTH-OFF_WIDTH-1){branch_offset[OFF_WIDTH-1]}},
                      branch_offset, 1'b0};

  assign tcnt_inc = tcnt + 8'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    tcnt_nx  = tcnt;
    err_nx   = fetch_error;

    unique case (state)
      IDLE: begin
        if (halt)     state_nx = HALT;
        else if (run) state_nx = FETCH;
      end
      FETCH: begin
        // halt is deliberately not looked at: an issued request must
        // either complete or time out.
        if (imem_ack) begin
          instr_nx = imem_rdata;
          tcnt_nx  = 8'd0;
          state_nx = EXEC;
        end else if (tcnt_inc == 8'(ACK_TIMEOUT)) begin
          err_nx   = 1'b1;
          tcnt_nx  = 8'd0;
          state_nx = HALT;
        end else begin
          tcnt_nx = tcnt_inc;
        end
      end
      EXEC: begin
        pc_nx    = pc + (taken ? off_bytes : PC_WIDTH'(2));
        state_nx = halt ? HALT : FETCH;
      end
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are registered copies of the next state, so they line up
  // exactly with the state they describe without any output decode logic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      tcnt        <= 8'd0;
      fetch_error <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state       <= state_nx;
      pc          <= pc_nx;
      instr       <= instr_nx;
      tcnt        <= tcnt_nx;
      fetch_error <= err_nx;
      imem_req    <= (state_nx == FETCH);
      instr_valid <= (state_nx == EXEC);
      halted      <= (state_nx == HALT);
    end
  end

`ifdef LEGLITE_FETCH_BRCNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      taken_count <= 16'h0000;
    end else if ((state == EXEC) && taken && (taken_count != 16'hFFFF)) begin
      taken_count <= taken_count + 16'd1;
    end
  end
`else
  assign taken_count = 16'h0000;
`endif

endmodule

// File: tb/tb_leglite_fetch.sv
// ---------------------------------------------------------------------------
// tb_leglite_fetch: self-checking bench for leglite_fetch.
//
// A memory/control driver issues fetch responses and EXEC-cycle branch
// inputs, and pushes the expected EXEC observation (instr, pc) and the
// expected next fetch address into queues, computed from a plain arithmetic
// PC model. A monitor on the falling edge pops and compares whenever the DUT
// strobes instr_valid or raises a new imem_req. Directed checks cover reset,
// halt, timeout and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_leglite_fetch;

  localparam int          ACK_TIMEOUT = 15;
  localparam logic [15:0] RESET_PC    = 16'h0000;

  logic        clock = 1'b0;
  logic        reset_n, run, halt;
  logic        imem_req, imem_ack, instr_valid;
  logic        branch, uncondbranch, alu_zero;
  logic        halted, fetch_error;
  logic [15:0] imem_addr, imem_rdata, instr, pc, taken_count;
  logic [3:0]  opcode;
  logic [8:0]  branch_offset;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } exec_t;

  exec_t       exec_q[$];
  logic [15:0] addr_q[$];
  exec_t       mon_e;
  logic        req_prev = 1'b0;

  logic [15:0] m_pc, m_instr;
  int          m_taken;

  always #5 clock = ~clock;

  leglite_fetch dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .run          (run),
    .halt         (halt),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .branch       (branch),
    .uncondbranch (uncondbranch),
    .alu_zero     (alu_zero),
    .branch_offset(branch_offset),
    .pc           (pc),
    .halted       (halted),
    .fetch_error  (fetch_error),
    .taken_count  (taken_count)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Next PC from the architectural rule, using signed integer arithmetic.
  function automatic logic [15:0] next_pc(input logic [15:0] cur,
                                          input bit tk,
                                          input logic [8:0] off);
    int o;
    int t;
    o = int'(off);
    if (o >= 256) o = o - 512;
    t = int'(cur) + (tk ? 2 * o : 2);
    return 16'(t & 32'h0000FFFF);
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef LEGLITE_FETCH_BRCNT_EN
    return (m_taken > 65535) ? 16'hFFFF : 16'(m_taken);
`else
    return 16'h0000;
`endif
  endfunction

  // Monitor: compares whenever the DUT presents an EXEC strobe or a new request.
  always @(negedge clock) begin
    if (!reset_n) begin
      req_prev = 1'b0;
    end else begin
      if (instr_valid) begin
        if (exec_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: instr_valid at pc 0x%0h, expected none", pc);
        end else begin
          mon_e = exec_q.pop_front();
          check("exec_instr", instr, mon_e.instr);
          check("exec_opcode", opcode, mon_e.instr[15:12]);
          check("exec_pc", pc, mon_e.pc);
        end
      end
      if (imem_req && !req_prev) begin
        if (addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: imem_req at addr 0x%0h, expected none", imem_addr);
        end else begin
          check("fetch_addr", imem_addr, addr_q.pop_front());
        end
      end
      req_prev = imem_req;
    end
  end

  task automatic scramble();
    branch        = 1'($urandom_range(0, 1));
    uncondbranch  = 1'($urandom_range(0, 1));
    alu_zero      = 1'($urandom_range(0, 1));
    branch_offset = 9'($urandom);
    imem_rdata    = 16'($urandom);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    run      = 1'b0;
    halt     = 1'b0;
    imem_ack = 1'b0;
    scramble();
    exec_q.delete();
    addr_q.delete();
    m_pc    = RESET_PC;
    m_instr = 16'h0000;
    m_taken = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Called from IDLE at #1 after an edge; returns in the first FETCH cycle.
  task automatic start_run();
    addr_q.push_back(m_pc);
    run = 1'b1;
    @(posedge clock);
    #1 run = 1'b0;
  endtask

  // Called in the first FETCH cycle; returns in the cycle after EXEC.
  task automatic do_fetch(input int delay, input logic [15:0] rdata,
                          input logic br, input logic ub, input logic z,
                          input logic [8:0] off, input logic stop);
    exec_t e;
    bit    tk;
    halt = stop;
    for (int i = 0; i < delay; i++) begin
      scramble();
      @(posedge clock);
      #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    e.instr = rdata;
    e.pc    = m_pc;
    exec_q.push_back(e);
    m_instr = rdata;
    @(posedge clock);
    #1;
    // EXEC cycle: a stray ack here must be ignored.
    imem_ack      = 1'($urandom_range(0, 1));
    imem_rdata    = 16'($urandom);
    branch        = br;
    uncondbranch  = ub;
    alu_zero      = z;
    branch_offset = off;
    tk = ub | (br & z);
    if (tk) m_taken++;
    m_pc = next_pc(m_pc, tk, off);
    if (!stop) addr_q.push_back(m_pc);
    @(posedge clock);
    #1;
    imem_ack = 1'b0;
    scramble();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit still_fetching;

    // Reset state
    do_reset();
    check("reset_pc", pc, RESET_PC);
    check("reset_addr", imem_addr, RESET_PC);
    check("reset_req", imem_req, 1'b0);
    check("reset_instr", instr, 16'h0000);
    check("reset_valid", instr_valid, 1'b0);
    check("reset_halted", halted, 1'b0);
    check("reset_error", fetch_error, 1'b0);
    check("reset_count", taken_count, 16'h0000);

    // Directed branch and wrap cases
    start_run();
    do_fetch(0, 16'h0123, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0); // 0000 -> 0002
    do_fetch(1, 16'hB000, 1'b0, 1'b1, 1'b0, 9'd7,   1'b0); // 0002 -> 0010
    do_fetch(0, 16'h1234, 1'b1, 1'b0, 1'b1, 9'h1FC, 1'b0); // 0010 -> 0008
    do_fetch(2, 16'h2345, 1'b0, 1'b1, 1'b0, 9'd4,   1'b0); // 0008 -> 0010
    do_fetch(0, 16'h3456, 1'b1, 1'b0, 1'b0, 9'h1FC, 1'b0); // 0010 -> 0012
    do_fetch(0, 16'h4567, 1'b0, 1'b1, 1'b0, 9'h1F6, 1'b0); // 0012 -> FFFE
    do_fetch(0, 16'h5678, 1'b0, 1'b1, 1'b1, 9'd3,   1'b0); // FFFE -> 0004
    do_fetch(0, 16'h6789, 1'b1, 1'b0, 1'b1, 9'h1FD, 1'b0); // 0004 -> FFFE
    do_fetch(0, 16'h789A, 1'b1, 1'b0, 1'b0, 9'h0AA, 1'b0); // FFFE -> 0000
    check("pc_wrap_seq", pc, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      do_fetch($urandom_range(0, ACK_TIMEOUT - 2), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 9'($urandom), 1'b0);
    end

    // halt raised during FETCH: fetch completes, one EXEC, then HALT
    do_fetch(3, 16'h7ABC, 1'b0, 1'b0, 1'b0, 9'h000, 1'b1);
    check("halt_halted", halted, 1'b1);
    check("halt_req", imem_req, 1'b0);
    check("halt_pc", pc, m_pc);
    check("halt_error", fetch_error, 1'b0);
    run = 1'b1;
    repeat (6) begin
      @(posedge clock);
      #1;
      imem_ack   = 1'b1;
      imem_rdata = 16'($urandom);
    end
    run      = 1'b0;
    imem_ack = 1'b0;
    check("halt_sticky", halted, 1'b1);
    check("halt_pc_frozen", pc, m_pc);
    check("halt_instr_frozen", instr, m_instr);
    check("halt_req_low", imem_req, 1'b0);
    check("count_after_random", taken_count, exp_count());

    // 3 taken + 2 not-taken, then asynchronous reset mid-FETCH
    do_reset();
    start_run();
    do_fetch(0, 16'h1111, 1'b0, 1'b1, 1'b0, 9'd8,   1'b0); // taken
    do_fetch(1, 16'h2222, 1'b1, 1'b0, 1'b1, 9'd5,   1'b0); // taken
    do_fetch(0, 16'h3333, 1'b1, 1'b0, 1'b0, 9'd5,   1'b0); // not taken
    do_fetch(0, 16'h4444, 1'b0, 1'b0, 1'b1, 9'h1F0, 1'b0); // not taken
    do_fetch(2, 16'h5555, 1'b1, 1'b1, 1'b0, 9'd2,   1'b0); // taken
    check("count_3_taken", taken_count, exp_count());
    @(posedge clock);
    #1;
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_req", imem_req, 1'b0);
    check("async_rst_pc", pc, RESET_PC);
    check("async_rst_instr", instr, 16'h0000);
    check("async_rst_count", taken_count, 16'h0000);

    // halt has priority over run in IDLE
    do_reset();
    halt = 1'b1;
    run  = 1'b1;
    @(posedge clock);
    #1;
    halt = 1'b0;
    run  = 1'b0;
    check("idle_halt_halted", halted, 1'b1);
    check("idle_halt_req", imem_req, 1'b0);

    // Ack timeout
    do_reset();
    start_run();
    still_fetching = 1'b1;
    for (int i = 1; i < ACK_TIMEOUT; i++) begin
      @(posedge clock);
      #1;
      if (!imem_req || halted || fetch_error) still_fetching = 1'b0;
    end
    check("timeout_not_early", still_fetching, 1'b1);
    @(posedge clock);
    #1;
    check("timeout_error", fetch_error, 1'b1);
    check("timeout_halted", halted, 1'b1);
    check("timeout_req", imem_req, 1'b0);
    imem_ack   = 1'b1;
    imem_rdata = 16'hFFFF;
    repeat (3) @(posedge clock);
    #1 imem_ack = 1'b0;
    check("late_ack_instr", instr, m_instr);
    check("late_ack_pc", pc, m_pc);
    check("late_ack_error", fetch_error, 1'b1);
    check("late_ack_halted", halted, 1'b1);

    @(negedge clock);
    check("exec_q_drained", exec_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
